// File: rtl/mem_port_arbiter.sv
// Shares one main-memory block port between the icache and dcache miss handlers.
// Optional performance counters are compiled in when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W      = 28,
  parameter int BLOCK_W     = 128,
  parameter int MAX_D_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [BLOCK_W-1:0] i_rdata,
  output logic               i_ack,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               d_ack,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_i_grants,
  output logic [31:0]        perf_d_grants,
  output logic [31:0]        perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t     state_reg;
  logic       issue_reg;
  logic [3:0] burst_reg;
  logic       burst_full;
  logic       grant_d_sel;
  logic       grant_i_sel;

  // Data wins ties until the icache has watched MAX_D_BURST data grants go by.
  assign burst_full  = (burst_reg == 4'(MAX_D_BURST));
  assign grant_d_sel = d_req && !(i_req && burst_full);
  assign grant_i_sel = i_req && !grant_d_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      issue_reg     <= 1'b0;
      burst_reg     <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_writedata <= '0;
      i_ack         <= 1'b0;
      d_ack         <= 1'b0;
      i_rdata       <= '0;
      d_rdata       <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!i_req) burst_reg <= '0;
          if (grant_d_sel) begin
            state_reg     <= GRANT_D;
            issue_reg     <= 1'b1;
            mem_read      <= !d_we;
            mem_write     <= d_we;
            mem_addr      <= d_addr;
            mem_writedata <= d_wdata;
            if (i_req) burst_reg <= burst_reg + 4'd1;
          end else if (grant_i_sel) begin
            state_reg <= GRANT_I;
            issue_reg <= 1'b1;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= i_addr;
            burst_reg <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          // busywait is not yet meaningful in the cycle the strobe is first issued
          issue_reg <= 1'b0;
          if (!issue_reg && !mem_busywait) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state_reg <= DONE;
            if (state_reg == GRANT_I) begin
              i_rdata <= mem_readdata;
              i_ack   <= 1'b1;
            end else begin
              if (mem_read) d_rdata <= mem_readdata;
              d_ack <= 1'b1;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_grants    <= '0;
      perf_d_grants    <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (state_reg == IDLE && grant_i_sel) perf_i_grants <= perf_i_grants + 32'd1;
      if (state_reg == IDLE && grant_d_sel) perf_d_grants <= perf_d_grants + 32'd1;
      if ((i_req && state_reg != GRANT_I) || (d_req && state_reg != GRANT_D))
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  localparam int ADDR_W      = 28;
  localparam int BLOCK_W     = 128;
  localparam int MAX_D_BURST = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               i_req, d_req, d_we;
  logic [ADDR_W-1:0]  i_addr, d_addr, mem_addr;
  logic [BLOCK_W-1:0] i_rdata, d_rdata, d_wdata, mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata = '0;
  logic               i_ack, d_ack, mem_read, mem_write;
  logic               mem_busywait = 1'b0;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]        perf_i_grants, perf_d_grants, perf_wait_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .MAX_D_BURST(MAX_D_BURST)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [BLOCK_W-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Memory model: busy for mem_lat cycles after a strobe first appears.
  int                 mem_lat = 0;
  bit                 rand_lat = 0;
  bit                 mem_fixed = 0;
  logic [BLOCK_W-1:0] mem_fixed_val = '0;
  logic [BLOCK_W-1:0] mem_data_cur = '0;
  bit                 mem_active = 0;
  int                 mem_cnt = 0;

  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      if (!mem_active) begin
        mem_active   = 1;
        mem_cnt      = rand_lat ? int'($urandom_range(0, 4)) : mem_lat;
        mem_data_cur = mem_fixed ? mem_fixed_val : rand_block();
        mem_readdata = mem_data_cur;
      end
      if (mem_cnt > 0) begin
        mem_busywait = 1'b1;
        mem_cnt      = mem_cnt - 1;
      end else begin
        mem_busywait = 1'b0;
      end
    end else begin
      mem_active   = 0;
      mem_busywait = 1'b0;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({mem_read, mem_write, i_ack, d_ack} !== 4'b0 || mem_addr !== '0 ||
        mem_writedata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rd=%b wr=%b iack=%b dack=%b addr=%h required all zero",
               mem_read, mem_write, i_ack, d_ack, mem_addr);
    end
  endtask

  task automatic test_i_read();
    int k;
    bit seen, bad;
    do_reset();
    mem_lat = 3; mem_fixed = 1; mem_fixed_val = {16{8'hA5}};
    i_addr = 28'h0000010; i_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000010) begin
      n_err++;
      $display("FAIL iread_issue: rd=%b wr=%b addr=%h required rd=1 wr=0 addr=0000010",
               mem_read, mem_write, mem_addr);
    end
    i_addr = 28'hFFFFFFF;
    k = 0; seen = 0; bad = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (i_ack === 1'b1) seen = 1;
      else if (mem_read !== 1'b1 || mem_addr !== 28'h0000010) bad = 1;
    end
    n_vec++;
    if (!seen || k != 4) begin
      n_err++;
      $display("FAIL iread_latency: ack seen=%0d after %0d cycles, required ack after 4", seen, k);
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL iread_hold: strobe/addr changed before ack, required held mem_read=1 addr=0000010");
    end
    n_vec++;
    if (i_rdata !== {16{8'hA5}} || mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL iread_data: i_rdata=%h mem_read=%b required a5..a5 and 0", i_rdata, mem_read);
    end
    i_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (i_ack !== 1'b0) begin
      n_err++;
      $display("FAIL iread_ack_pulse: i_ack=%b one cycle after ack, required 0", i_ack);
    end
    mem_fixed = 0;
  endtask

  task automatic test_d_write();
    int k;
    bit seen, bad;
    do_reset();
    mem_lat = 2;
    d_we = 1'b1; d_addr = 28'h0000020; d_wdata = {8{16'h1234}}; d_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h0000020 ||
        mem_writedata !== {8{16'h1234}}) begin
      n_err++;
      $display("FAIL dwrite_issue: rd=%b wr=%b addr=%h wdata=%h required rd=0 wr=1 addr=0000020 wdata=1234..",
               mem_read, mem_write, mem_addr, mem_writedata);
    end
    d_addr = 28'h0ABCDEF; d_wdata = '1; d_we = 1'b0;
    k = 0; seen = 0; bad = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (mem_read === 1'b1) bad = 1;
      if (d_ack === 1'b1) seen = 1;
      else if (mem_write !== 1'b1 || mem_addr !== 28'h0000020 ||
               mem_writedata !== {8{16'h1234}}) bad = 1;
    end
    n_vec++;
    if (!seen || k != 3) begin
      n_err++;
      $display("FAIL dwrite_latency: ack seen=%0d after %0d cycles, required ack after 3", seen, k);
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL dwrite_hold: write strobe/addr/data unstable or mem_read seen, required stable write");
    end
    n_vec++;
    if (d_rdata !== '0 || mem_write !== 1'b0) begin
      n_err++;
      $display("FAIL dwrite_done: d_rdata=%h mem_write=%b required 0 and 0", d_rdata, mem_write);
    end
    d_req = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [ADDR_W-1:0] grants[$];
    int acks[$];
    bit prev_strobe, overlap;
    int k;
    do_reset();
    mem_lat = 1;
    i_addr = 28'h0000100; d_addr = 28'h0000200; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    prev_strobe = 0; overlap = 0; k = 0;
    while (acks.size() < 2 && k < 60) begin
      @(negedge clk);
      k++;
      if ((mem_read && mem_write) || (i_ack && d_ack)) overlap = 1;
      if ((mem_read || mem_write) && !prev_strobe) grants.push_back(mem_addr);
      prev_strobe = mem_read || mem_write;
      if (d_ack) begin acks.push_back(2); d_req = 1'b0; end
      if (i_ack) begin acks.push_back(1); i_req = 1'b0; end
    end
    n_vec++;
    if (acks.size() != 2 || grants.size() != 2) begin
      n_err++;
      $display("FAIL simul_complete: %0d acks %0d grants, required 2 and 2", acks.size(), grants.size());
    end else begin
      n_vec++;
      if (grants[0] !== 28'h0000200 || grants[1] !== 28'h0000100 || acks[0] != 2 || acks[1] != 1) begin
        n_err++;
        $display("FAIL simul_order: grants %h,%h acks %0d,%0d required 0000200,0000100 and d(2),i(1)",
                 grants[0], grants[1], acks[0], acks[1]);
      end
    end
    n_vec++;
    if (overlap) begin
      n_err++;
      $display("FAIL simul_overlap: overlapping strobes or acks seen, required none");
    end
  endtask

  task automatic test_burst();
    int g, k;
    bit prev_strobe;
    logic [ADDR_W-1:0] want;
    do_reset();
    mem_lat = 0;
    i_addr = 28'h0000100; d_addr = 28'h0000200; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    g = 0; k = 0; prev_strobe = 0;
    while (g < 10 && k < 300) begin
      @(negedge clk);
      k++;
      if ((mem_read || mem_write) && !prev_strobe) begin
        want = (g % 5 == 4) ? 28'h0000100 : 28'h0000200;
        n_vec++;
        if (mem_addr !== want) begin
          n_err++;
          $display("FAIL burst_grant%0d: addr=%h required %h", g, mem_addr, want);
        end
        g++;
      end
      prev_strobe = mem_read || mem_write;
    end
    n_vec++;
    if (g != 10) begin
      n_err++;
      $display("FAIL burst_timeout: %0d grants seen, required 10", g);
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit bad;
    do_reset();
    mem_lat = 5;
    d_we = 1'b1; d_addr = 28'h0000333; d_wdata = rand_block(); d_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (mem_write !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_issue: mem_write=%b required 1", mem_write);
    end
    @(negedge clk);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mem_read, mem_write, i_ack, d_ack} !== 4'b0 || mem_addr !== '0 ||
        mem_writedata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: rd=%b wr=%b iack=%b dack=%b addr=%h required all zero",
               mem_read, mem_write, i_ack, d_ack, mem_addr);
    end
    reset = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (d_ack !== 1'b0 || mem_write !== 1'b0 || mem_read !== 1'b0) bad = 1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL rstmid_no_ack: ack or strobe seen after abandoned transfer, required none");
    end
  endtask

  // Transaction-level model: who should win each idle edge, what the memory
  // should see during the grant, and what each requester should get back.
  task automatic test_random();
    int owner, burst, busy_cyc;
    bit done_next, idle_edge, strobe, exp_grant, exp_rd, exp_wr;
    logic s_ireq, s_dreq, s_dwe;
    logic [ADDR_W-1:0] s_iaddr, s_daddr, exp_addr;
    logic [BLOCK_W-1:0] s_dwdata, exp_wdata, d_rdata_exp;
    do_reset();
    rand_lat = 1;
    owner = 0; burst = 0; done_next = 0; busy_cyc = 0;
    exp_addr = '0; exp_wdata = '0; exp_wr = 0; d_rdata_exp = '0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(posedge clk);
      s_ireq = i_req; s_iaddr = i_addr; s_dreq = d_req;
      s_dwe = d_we; s_daddr = d_addr; s_dwdata = d_wdata;
      idle_edge = (owner == 0) && !done_next;
      done_next = 0;
      @(negedge clk);
      strobe = mem_read || mem_write;
      if (idle_edge) begin
        exp_grant = s_ireq || s_dreq;
        n_vec++;
        if (strobe !== exp_grant) begin
          n_err++;
          $display("FAIL rand_grant_presence cyc %0d: strobe=%b required %b", cyc, strobe, exp_grant);
        end
        if (!s_ireq) burst = 0;
        if (s_dreq && !(s_ireq && burst == MAX_D_BURST)) begin
          owner = 2; exp_addr = s_daddr; exp_wr = s_dwe; exp_wdata = s_dwdata;
          if (s_ireq) burst++;
          busy_cyc = 0;
        end else if (s_ireq) begin
          owner = 1; exp_addr = s_iaddr; exp_wr = 0;
          burst = 0; busy_cyc = 0;
        end
      end
      n_vec++;
      if ((mem_read && mem_write) || (i_ack && d_ack)) begin
        n_err++;
        $display("FAIL rand_exclusive cyc %0d: rd=%b wr=%b iack=%b dack=%b required no pair both 1",
                 cyc, mem_read, mem_write, i_ack, d_ack);
      end
      if (i_ack || d_ack) begin
        n_vec++;
        if ((i_ack && owner != 1) || (d_ack && owner != 2) || strobe) begin
          n_err++;
          $display("FAIL rand_ack_owner cyc %0d: iack=%b dack=%b strobe=%b owner=%0d required ack of owner, strobe 0",
                   cyc, i_ack, d_ack, strobe, owner);
        end
        if (owner == 2 && !exp_wr) d_rdata_exp = mem_data_cur;
        n_vec++;
        if ((owner == 1 && i_rdata !== mem_data_cur) || d_rdata !== d_rdata_exp) begin
          n_err++;
          $display("FAIL rand_rdata cyc %0d: i_rdata=%h d_rdata=%h required mem=%h d=%h",
                   cyc, i_rdata, d_rdata, mem_data_cur, d_rdata_exp);
        end
        if (i_ack) i_req = 1'b0;
        if (d_ack) d_req = 1'b0;
        owner = 0; done_next = 1;
      end else if (owner != 0) begin
        exp_rd = (owner == 1) || !exp_wr;
        n_vec++;
        if (mem_read !== exp_rd || mem_write !== (owner == 2 && exp_wr) || mem_addr !== exp_addr ||
            (owner == 2 && exp_wr && mem_writedata !== exp_wdata)) begin
          n_err++;
          $display("FAIL rand_strobe cyc %0d: rd=%b wr=%b addr=%h wdata=%h required rd=%b wr=%b addr=%h wdata=%h",
                   cyc, mem_read, mem_write, mem_addr, mem_writedata, exp_rd,
                   (owner == 2 && exp_wr), exp_addr, exp_wdata);
        end
        busy_cyc++;
        if (busy_cyc > 12) begin
          n_vec++; n_err++;
          $display("FAIL rand_timeout cyc %0d: no ack after %0d grant cycles, required at most 12", cyc, busy_cyc);
          break;
        end
      end
      if ($urandom_range(0, 1) == 0) i_addr = {1'b0, 27'($urandom)};
      if ($urandom_range(0, 1) == 0) begin
        d_addr = {1'b1, 27'($urandom)}; d_we = 1'($urandom); d_wdata = rand_block();
      end
      if (i_req && $urandom_range(0, 19) == 0) i_req = 1'b0;
      else if (!i_req && owner != 1 && $urandom_range(0, 2) == 0) i_req = 1'b1;
      if (d_req && $urandom_range(0, 19) == 0) d_req = 1'b0;
      else if (!d_req && owner != 2 && $urandom_range(0, 1) == 0) d_req = 1'b1;
    end
    rand_lat = 0;
    i_req = 1'b0; d_req = 1'b0;
  endtask

`ifdef MEM_ARB_PERF_CNT_EN
  task automatic test_perf();
    int k;
    bit got;
    do_reset();
    mem_lat = 1;
    for (int t = 0; t < 5; t++) begin
      if (t < 3) begin i_addr = 28'h0000040 + 28'(t); i_req = 1'b1; end
      else begin d_addr = 28'h0000080 + 28'(t); d_we = 1'(t); d_req = 1'b1; end
      got = 0; k = 0;
      while (!got && k < 30) begin
        @(negedge clk);
        k++;
        if (i_ack || d_ack) got = 1;
      end
      n_vec++;
      if (!got) begin
        n_err++;
        $display("FAIL perf_xfer%0d: no ack within 30 cycles, required ack", t);
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (perf_i_grants !== 32'd3 || perf_d_grants !== 32'd2) begin
      n_err++;
      $display("FAIL perf_counts: i=%0d d=%0d required 3 and 2", perf_i_grants, perf_d_grants);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (perf_i_grants !== '0 || perf_d_grants !== '0 || perf_wait_cycles !== '0) begin
      n_err++;
      $display("FAIL perf_reset: i=%0d d=%0d wait=%0d required all 0",
               perf_i_grants, perf_d_grants, perf_wait_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_burst();
    test_reset_mid();
    test_random();
`ifdef MEM_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
